// File: rtl/result_writeback.sv
// Writeback sequencer: drives the single register-file write port from ALU results,
// splitting 64-bit long-multiply products into RdLo then RdHi writes, and owns NZCV.
module result_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] Result,
  input  logic [63:0] LongMulResult,
  input  logic [3:0]  ALUFlags,
  input  logic [2:0]  MulFunct,
  input  logic        RegWrite,
  input  logic [1:0]  FlagWrite,
  input  logic [3:0]  Rd,
  input  logic [3:0]  RdHi,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [3:0]  Flags
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_HI_PEND = 1'b1;

  logic        state_q,   state_d;
  logic        we_q,      we_d;
  logic [3:0]  wa_q,      wa_d;
  logic [31:0] wd_q,      wd_d;
  logic [3:0]  flags_q,   flags_d;
  logic [31:0] hi_word_q, hi_word_d;
  logic [3:0]  hi_rd_q,   hi_rd_d;

  logic accept;
  logic is_long_fn;

  assign ready_out  = (state_q == ST_IDLE);
  assign accept     = valid_in & ready_out;
  assign is_long_fn = (MulFunct == 3'b100) || (MulFunct == 3'b110);

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    flags_d   = flags_q;
    hi_word_d = hi_word_q;
    hi_rd_d   = hi_rd_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_long_fn) begin
            // Long ops derive N,Z from the full product; C,V are never touched.
            if (FlagWrite[1]) begin
              flags_d[3] = LongMulResult[63];
              flags_d[2] = (LongMulResult == 64'd0);
            end
            if (RegWrite) begin
              we_d      = 1'b1;
              wa_d      = Rd;
              wd_d      = LongMulResult[31:0];
              hi_word_d = LongMulResult[63:32];
              hi_rd_d   = RdHi;
              state_d   = ST_HI_PEND;
            end
          end else begin
            we_d = RegWrite;
            wa_d = Rd;
            wd_d = Result;
            if (FlagWrite[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWrite[0]) flags_d[1:0] = ALUFlags[1:0];
          end
        end
      end
      default: begin
        we_d    = 1'b1;
        wa_d    = hi_rd_q;
        wd_d    = hi_word_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      wa_q      <= 4'd0;
      wd_q      <= 32'd0;
      flags_q   <= 4'd0;
      hi_word_q <= 32'd0;
      hi_rd_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      flags_q   <= flags_d;
      hi_word_q <= hi_word_d;
      hi_rd_q   <= hi_rd_d;
    end
  end

  assign rf_we = we_q;
  assign rf_wa = wa_q;
  assign rf_wd = wd_q;
  assign Flags = flags_q;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: directed scenarios then random traffic, all checked
// against a schedule-of-writes reference model.
module tb_result_writeback;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] Result;
  logic [63:0] LongMulResult;
  logic [3:0]  ALUFlags;
  logic [2:0]  MulFunct;
  logic        RegWrite;
  logic [1:0]  FlagWrite;
  logic [3:0]  Rd;
  logic [3:0]  RdHi;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [3:0]  Flags;

  result_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .Result       (Result),
    .LongMulResult(LongMulResult),
    .ALUFlags     (ALUFlags),
    .MulFunct     (MulFunct),
    .RegWrite     (RegWrite),
    .FlagWrite    (FlagWrite),
    .Rd           (Rd),
    .RdHi         (RdHi),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .Flags        (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
  } wr_t;

  // Model: each accepted op appends the register-file writes it owes, one per cycle.
  wr_t      sched[$];
  logic [3:0] m_flags;
  logic       m_ready;
  int         compared;
  int         mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    m_flags = 4'd0;
    m_ready = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [2:0] mf, input logic rw, input logic [1:0] fw,
                       input logic [3:0] af, input logic [3:0] rd, input logic [3:0] rdhi,
                       input logic [31:0] res, input logic [63:0] lmr);
    valid_in      = v;
    MulFunct      = mf;
    RegWrite      = rw;
    FlagWrite     = fw;
    ALUFlags      = af;
    Rd            = rd;
    RdHi          = rdhi;
    Result        = res;
    LongMulResult = lmr;
  endtask

  task automatic tick();
    wr_t w;
    bit  is_long;
    @(posedge clk);
    if (m_ready && valid_in) begin
      is_long = (MulFunct == 3'b100) || (MulFunct == 3'b110);
      if (is_long) begin
        if (FlagWrite[1]) begin
          m_flags[3] = LongMulResult[63];
          m_flags[2] = (LongMulResult == 64'd0);
        end
        if (RegWrite) begin
          sched.push_back({1'b1, Rd, LongMulResult[31:0]});
          sched.push_back({1'b1, RdHi, LongMulResult[63:32]});
        end
      end else begin
        if (FlagWrite[1]) m_flags[3:2] = ALUFlags[3:2];
        if (FlagWrite[0]) m_flags[1:0] = ALUFlags[1:0];
        sched.push_back({RegWrite, Rd, Result});
      end
    end
    if (sched.size() == 0) begin
      w = '0;
      sched.push_back(w);
    end
    w       = sched.pop_front();
    m_ready = (sched.size() == 0);
    #1;
    check("rf_we", 32'(rf_we), 32'(w.we));
    if (w.we) begin
      check("rf_wa", 32'(rf_wa), 32'(w.wa));
      check("rf_wd", rf_wd, w.wd);
    end
    check("flags", 32'(Flags), 32'(m_flags));
    check("ready_out", 32'(ready_out), 32'(m_ready));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_reset();
    reset = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("por_we", 32'(rf_we), 32'd0);
    check("por_wa", 32'(rf_wa), 32'd0);
    check("por_wd", rf_wd, 32'd0);
    check("por_flags", 32'(Flags), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("ready_after_release", 32'(ready_out), 32'd1);

    // Short op
    drive(1'b1, 3'b000, 1'b1, 2'b11, 4'b0110, 4'd3, 4'd0, 32'h0000_00A5, 64'h0);
    tick();
    check("short_we", 32'(rf_we), 32'd1);
    check("short_wa", 32'(rf_wa), 32'd3);
    check("short_wd", rf_wd, 32'h0000_00A5);
    check("short_flags", 32'(Flags), 32'b0110);

    // Mid-cycle reset clears immediately
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);
    check("rst_wd", rf_wd, 32'd0);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    #1 reset = 1'b1;
    tick();
    check("rst_ready", 32'(ready_out), 32'd1);

    // Prior flags = 0011, then UMULL back-to-back with a short op to r6
    drive(1'b1, 3'b000, 1'b0, 2'b11, 4'b0011, 4'd0, 4'd0, 32'h0, 64'h0);
    tick();
    check("prior_flags", 32'(Flags), 32'b0011);
    drive(1'b1, 3'b100, 1'b1, 2'b10, 4'b1111, 4'd4, 4'd5, 32'h0, 64'h0000_0001_FFFF_FFFE);
    tick();
    check("umull_lo_wa", 32'(rf_wa), 32'd4);
    check("umull_lo_wd", rf_wd, 32'hFFFF_FFFE);
    check("umull_lo_ready", 32'(ready_out), 32'd0);
    check("umull_flags", 32'(Flags), 32'b0011);
    drive(1'b1, 3'b000, 1'b1, 2'b00, 4'h0, 4'd6, 4'd0, 32'h0000_C0DE, 64'h0);
    tick();
    check("umull_hi_we", 32'(rf_we), 32'd1);
    check("umull_hi_wa", 32'(rf_wa), 32'd5);
    check("umull_hi_wd", rf_wd, 32'h0000_0001);
    check("umull_hi_ready", 32'(ready_out), 32'd1);
    tick();
    check("follow_wa", 32'(rf_wa), 32'd6);
    check("follow_wd", rf_wd, 32'h0000_C0DE);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    tick();

    // SMULL negative, then zero product with disagreeing ALUFlags
    drive(1'b1, 3'b110, 1'b1, 2'b11, 4'b0000, 4'd1, 4'd2, 32'h0, 64'h8000_0000_0000_0000);
    tick();
    check("smull_neg_flags", 32'(Flags), 32'b1011);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    tick();
    drive(1'b1, 3'b110, 1'b1, 2'b11, 4'b1000, 4'd1, 4'd2, 32'h0, 64'h0);
    tick();
    check("smull_zero_flags", 32'(Flags), 32'b0111);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    tick();

    // Reset while the high half is pending
    drive(1'b1, 3'b100, 1'b1, 2'b00, 4'h0, 4'd8, 4'd9, 32'h0, 64'h1234_5678_9ABC_DEF0);
    tick();
    check("hp_lo_wa", 32'(rf_wa), 32'd8);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("hp_rst_we", 32'(rf_we), 32'd0);
    #2 reset = 1'b1;
    repeat (3) tick();
    check("hp_ready", 32'(ready_out), 32'd1);

    // RdHi == RdLo
    drive(1'b1, 3'b100, 1'b1, 2'b00, 4'h0, 4'd7, 4'd7, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check("same_lo_wa", 32'(rf_wa), 32'd7);
    check("same_lo_wd", rf_wd, 32'hCCCC_DDDD);
    drive(1'b0, 3'b000, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0);
    tick();
    check("same_hi_wa", 32'(rf_wa), 32'd7);
    check("same_hi_wd", rf_wd, 32'hAAAA_BBBB);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  mf;
      logic        rw;
      logic [63:0] p;
      case ($urandom_range(0, 3))
        0:       mf = 3'b100;
        1:       mf = 3'b110;
        default: mf = 3'($urandom_range(0, 7));
      endcase
      rw = 1'($urandom_range(0, 1));
      if (mf == 3'b100 || mf == 3'b110) rw = 1'b1;
      p = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) p = 64'd0;
      drive(1'($urandom_range(0, 3) != 0), mf, rw, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            32'($urandom), p);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
# result_writeback

Writeback sequencer directly downstream of the execute-stage ALU. It accepts one ALU result per handshake and drives the register file's single write port. UMULL/SMULL 64-bit results are split into two writes on consecutive cycles, RdLo then RdHi, and upstream is stalled for the extra cycle. The block also owns the architectural NZCV flag register, which it updates from ALU flags or from the 64-bit product.

## Interface
- No parameters. Data width is fixed at 32, the long result at 64, and register addresses at 4 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `valid_in`  in  1  execute stage presents an operation.
- `ready_out`  out  1  block can accept; transfer happens when `valid_in & ready_out` at a rising edge.
- `Result`  in  32  ALU 32-bit result.
- `LongMulResult`  in  64  ALU 64-bit product; meaningful only for long ops.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU.
- `MulFunct`  in  3  `100` = UMULL, `110` = SMULL; any other value is a 32-bit op.
- `RegWrite`  in  1  operation writes the register file.
- `FlagWrite`  in  2  bit1 enables the N,Z update; bit0 enables the C,V update.
- `Rd`  in  4  destination register, which is RdLo for long ops.
- `RdHi`  in  4  high destination for long ops.
- `rf_we`  out  1  register file write enable (registered).
- `rf_wa`  out  4  write address (registered).
- `rf_wd`  out  32  write data (registered).
- `Flags`  out  4  architectural {N,Z,C,V} (registered).

## Operation
- States:
  - IDLE
  - HI_PEND: low half issued, high half still owed.
- A long op is an accepted transfer with `MulFunct` ∈ {100, 110} and `RegWrite=1`. A long op with `RegWrite=0` updates flags only and issues no writes.
- IDLE:
  - `ready_out=1`.
  - On a short accept: load `rf_we=RegWrite`, `rf_wa=Rd`, `rf_wd=Result`. Stay in IDLE.
  - On a long accept: load `rf_we=1`, `rf_wa=Rd`, `rf_wd=LongMulResult[31:0]`. Latch `LongMulResult[63:32]` and `RdHi` into internal registers. Go to HI_PEND.
  - With no accept: `rf_we=0` (address and data hold).
- HI_PEND:
  - `ready_out=0`; `valid_in` is ignored.
  - Next edge loads `rf_we=1`, `rf_wa`=latched RdHi, `rf_wd`=latched high word, then returns to IDLE.
- Flags are updated only on an accepted transfer:
  - Short op: if `FlagWrite[1]`, N,Z ← `ALUFlags[3:2]`; if `FlagWrite[0]`, C,V ← `ALUFlags[1:0]`.
  - Long op with `FlagWrite[1]`: N ← `LongMulResult[63]` and Z ← (`LongMulResult` == 0), both computed here and not taken from `ALUFlags`. C,V are always preserved for long ops, regardless of `FlagWrite[0]`.
- RdHi == RdLo: both writes issue; the high word lands last and therefore wins.
- Reset values: state=IDLE, `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `Flags=0000`, latched high word 0, latched RdHi 0. `ready_out=1` once reset is released.
- Reset asserted in HI_PEND: the pending high write is discarded and the block returns to IDLE; no write appears after release.

## Timing
- Latency: an op accepted at edge E shows its write on `rf_*` during the cycle after E, so the register file commits it at edge E+1.
- Long op accepted at E0:
  - low write is visible after E0;
  - `ready_out=0` between E0 and E1;
  - high write is visible after E1;
  - `ready_out=1` after E1.
  - Throughput is one long op per 2 cycles.
- Short ops sustain one per cycle with `ready_out` held high.
- `Flags` change on the accept edge and are visible in the following cycle; there is no flag change in HI_PEND.
- `ready_out` is a pure function of state, with no combinational path from `valid_in`.

## Test plan
- Reset check: drive `reset=0` mid-cycle → outputs clear immediately (`rf_we=0`, `Flags=0000`); after release, `ready_out=1`.
- Short op: `Result=0x0000_00A5`, `Rd=3`, `RegWrite=1`, `FlagWrite=11`, `ALUFlags=0110` → next cycle `rf_we=1`, `rf_wa=3`, `rf_wd=0xA5`, `Flags=0110`.
- UMULL back-to-back:
  - Stimulus: `LongMulResult=0x0000_0001_FFFF_FFFE`, `Rd=4`, `RdHi=5`, `FlagWrite=10`, prior `Flags=0011`. Keep `valid_in` high with a following short op to `Rd=6`.
  - Required response:
    - cycle 1: write (4, `0xFFFF_FFFE`), `ready_out=0`;
    - cycle 2: write (5, `0x0000_0001`);
    - cycle 3: write to 6;
    - `Flags=0011` (N=0, Z=0, C,V kept).
- SMULL zero/negative:
  - product `0x8000_0000_0000_0000` → N=1, Z=0;
  - product 0 → Z=1, even if `ALUFlags` disagrees.
- Reset during HI_PEND: assert `reset` the cycle after a long accept → no RdHi write ever appears; `ready_out=1` after release.
- RdHi == RdLo == 7 → two consecutive writes to r7, low word then high word.
